// File: rtl/hazard_control_unit.sv
// Stall/flush controller for the 5-stage pipeline.
// Handles hazards that bypassing cannot resolve: load-use, taken branches and
// multi-cycle multiply. Optional performance counters are enabled by defining
// HAZARD_PERF_COUNT_EN (adds stall_cycles and flush_count outputs).
module hazard_control_unit #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned REG_ADDR_W  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] ID_rs,
  input  logic [REG_ADDR_W-1:0] ID_rt,
  input  logic                  ID_useRt,
  input  logic                  ID_EX_memRead,
  input  logic [REG_ADDR_W-1:0] ID_EX_rt,
  input  logic                  EX_branchTaken,
  input  logic                  EX_mulStart,
  output logic                  PC_write,
  output logic                  IF_ID_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_bubble,
  output logic                  EX_stall,
`ifdef HAZARD_PERF_COUNT_EN
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_count,
`endif
  output logic                  mul_busy
);

  typedef enum logic [0:0] {StRun, StMulWait} state_e;

  // Number of MUL_WAIT cycles still to come after the start cycle.
  localparam logic [3:0] MulInit = 4'(MUL_LATENCY - 2);

  state_e     state_q, state_d;
  logic [3:0] mul_cnt_q, mul_cnt_d;
  logic       load_use;

  // Register 0 is hard-wired, so a load targeting it never creates a dependency.
  assign load_use = ID_EX_memRead && (ID_EX_rt != '0) &&
                    ((ID_EX_rt == ID_rs) || (ID_useRt && (ID_EX_rt == ID_rt)));

  // Next-state and pipeline-control decode.
  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_bubble = 1'b0;
    EX_stall     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (EX_branchTaken) begin
          // ID instruction and any multiply in EX are on the wrong path.
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (EX_mulStart) begin
          PC_write    = 1'b0;
          IF_ID_write = 1'b0;
          EX_stall    = 1'b1;
          mul_cnt_d   = MulInit;
          // A 2-cycle multiply needs only this start-cycle stall.
          if (MulInit != 4'd0) state_d = StMulWait;
        end else if (load_use) begin
          PC_write     = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      end
      StMulWait: begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        EX_stall    = 1'b1;
        mul_cnt_d   = mul_cnt_q - 4'd1;
        // Leave as the count reaches zero; the multiply exits EX next cycle.
        if (mul_cnt_q <= 4'd1) state_d = StRun;
      end
      default: state_d = StRun;
    endcase
    // Reset releases the pipeline immediately regardless of inputs.
    if (!rst_n) begin
      PC_write     = 1'b1;
      IF_ID_write  = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      EX_stall     = 1'b0;
    end
  end

  // State and multiply counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StRun;
      mul_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      mul_cnt_q <= mul_cnt_d;
    end
  end

  assign mul_busy = (state_q == StMulWait);

`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0] stall_cycles_q;
  logic [15:0] flush_count_q;

  // Saturating counters of fetch-stall cycles and flush cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (!PC_write && (stall_cycles_q != '1)) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (IF_ID_flush && (flush_count_q != '1)) flush_count_q <= flush_count_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed boundary cases with
// literal expectations plus randomized traffic against a behavioural model.
module tb_hazard_control_unit;

  localparam int unsigned LAT = 4;
  localparam int unsigned AW  = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] ID_rs = '0, ID_rt = '0, ID_EX_rt = '0;
  logic          ID_useRt = 1'b0, ID_EX_memRead = 1'b0;
  logic          EX_branchTaken = 1'b0, EX_mulStart = 1'b0;
  logic          PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall, mul_busy;
`ifdef HAZARD_PERF_COUNT_EN
  logic [31:0]   stall_cycles;
  logic [15:0]   flush_count;
`endif

  hazard_control_unit #(.MUL_LATENCY(LAT), .REG_ADDR_W(AW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ID_rs          (ID_rs),
    .ID_rt          (ID_rt),
    .ID_useRt       (ID_useRt),
    .ID_EX_memRead  (ID_EX_memRead),
    .ID_EX_rt       (ID_EX_rt),
    .EX_branchTaken (EX_branchTaken),
    .EX_mulStart    (EX_mulStart),
    .PC_write       (PC_write),
    .IF_ID_write    (IF_ID_write),
    .IF_ID_flush    (IF_ID_flush),
    .ID_EX_bubble   (ID_EX_bubble),
    .EX_stall       (EX_stall),
`ifdef HAZARD_PERF_COUNT_EN
    .stall_cycles   (stall_cycles),
    .flush_count    (flush_count),
`endif
    .mul_busy       (mul_busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: MUL_WAIT cycles still owed, and event counts so far.
  int mul_left = 0;
  int m_stalls = 0;
  int m_flushes = 0;

  // Output vector order: {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall, mul_busy}
  function automatic logic [5:0] outs();
    return {PC_write, IF_ID_write, IF_ID_flush, ID_EX_bubble, EX_stall, mul_busy};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs after the edge, compare at the falling edge,
  // then advance the model to the next cycle.
  task automatic cycle(input logic [AW-1:0] rs, input logic [AW-1:0] rt, input logic use_rt,
                       input logic mem_rd, input logic [AW-1:0] ex_rt, input logic br,
                       input logic mul, output logic [5:0] got);
    logic [5:0] exp;
    logic       lu;
    int         next_left;
    @(posedge clk);
    #1;
    ID_rs = rs; ID_rt = rt; ID_useRt = use_rt; ID_EX_memRead = mem_rd;
    ID_EX_rt = ex_rt; EX_branchTaken = br; EX_mulStart = mul;
    lu = mem_rd && (ex_rt != 0) && (ex_rt == rs || (use_rt && ex_rt == rt));
    next_left = 0;
    if (mul_left > 0) begin
      exp = 6'b000011;
      next_left = mul_left - 1;
    end else if (br) begin
      exp = 6'b111100;
    end else if (mul) begin
      exp = 6'b000010;
      next_left = int'(LAT) - 2;
    end else if (lu) begin
      exp = 6'b000100;
    end else begin
      exp = 6'b110000;
    end
    @(negedge clk);
    got = outs();
    check("model", {26'd0, got}, {26'd0, exp});
`ifdef HAZARD_PERF_COUNT_EN
    check("stall_cycles", stall_cycles, m_stalls);
    check("flush_count", {16'd0, flush_count}, m_flushes);
`endif
    if (!exp[5]) m_stalls++;
    if (exp[3]) m_flushes++;
    mul_left = next_left;
  endtask

  task automatic idle(output logic [5:0] got);
    cycle('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, got);
  endtask

  task automatic model_reset();
    mul_left = 0;
    m_stalls = 0;
    m_flushes = 0;
  endtask

  initial begin
    logic [5:0] g;
    // Reset state
    #12;
    check("reset_outs", {26'd0, outs()}, 32'b110000);
    rst_n = 1'b1;
    model_reset();

    idle(g);
    check("idle", {26'd0, g}, 32'b110000);

    // Load-use on rs, and register 0 exemption
    cycle(5'd8, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, g);
    check("lu_rs", {26'd0, g}, 32'b000100);
    idle(g);
    check("lu_one_cycle", {26'd0, g}, 32'b110000);
    cycle(5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, g);
    check("lu_r0", {26'd0, g}, 32'b110000);

    // rt dependency only counts when rt is a source
    cycle(5'd1, 5'd9, 1'b0, 1'b1, 5'd9, 1'b0, 1'b0, g);
    check("lu_rt_unused", {26'd0, g}, 32'b110000);
    cycle(5'd1, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, g);
    check("lu_rt_used", {26'd0, g}, 32'b000100);

    // Multiply: 3 stall cycles, mul_busy on the last two
    cycle('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, g);
    check("mul_start", {26'd0, g}, 32'b000010);
    idle(g);
    check("mul_wait1", {26'd0, g}, 32'b000011);
    // Branch, mul and load-use are ignored in MUL_WAIT
    cycle(5'd8, '0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, g);
    check("mul_wait2", {26'd0, g}, 32'b000011);
    // Back-to-back multiply in the first RUN cycle restarts the sequence
    cycle('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, g);
    check("mul_b2b_start", {26'd0, g}, 32'b000010);
    idle(g);
    idle(g);
    check("mul_b2b_wait2", {26'd0, g}, 32'b000011);
    // load_use held through the end is re-evaluated on return to RUN
    cycle(5'd3, '0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, g);
    check("lu_after_mul", {26'd0, g}, 32'b000100);

    // Branch wins over mul and load-use
    cycle(5'd8, '0, 1'b0, 1'b1, 5'd8, 1'b1, 1'b1, g);
    check("branch_prio", {26'd0, g}, 32'b111100);
    idle(g);
    check("after_branch", {26'd0, g}, 32'b110000);

    // Reset during the second MUL_WAIT cycle
    cycle('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, g);
    idle(g);
    @(posedge clk);
    #1;
    ID_rs = 5'd7; ID_EX_rt = 5'd7; ID_EX_memRead = 1'b1;
    #1;
    check("mid_mul_pre_reset", {26'd0, outs()}, 32'b000011);
    rst_n = 1'b0;
    #1;
    check("mid_mul_reset", {26'd0, outs()}, 32'b110000);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(g);
    check("post_reset", {26'd0, g}, 32'b110000);

`ifdef HAZARD_PERF_COUNT_EN
    // One load-use, one multiply, two flushes from a clean reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
    cycle(5'd8, '0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, g);
    cycle('0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b1, g);
    idle(g);
    idle(g);
    cycle('0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, g);
    cycle('0, '0, 1'b0, 1'b0, '0, 1'b1, 1'b0, g);
    idle(g);
    check("perf_stalls", stall_cycles, 32'd4);
    check("perf_flushes", {16'd0, flush_count}, 32'd2);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      cycle(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 1'($urandom),
            1'($urandom), AW'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 7) == 0), g);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
